// File: rtl/ram_dualport_sync_param.sv
// Parametrised single-clock simple dual-port RAM with per-byte write enables,
// selectable read-during-write behaviour and a sequenced clear sweep.
module ram_dualport_sync_param #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_SIZE  = 3,
    parameter int BYTE_W     = 8,
    parameter int RDW_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VAL = '0,
    localparam int DEPTH  = 2**ADDR_SIZE,
    localparam int NUM_BE = DATA_WIDTH/BYTE_W
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  init,
    output logic                  busy,
    input  logic                  we,
    input  logic [ADDR_SIZE-1:0]  wr_addr,
    input  logic [NUM_BE-1:0]     be,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  re,
    input  logic [ADDR_SIZE-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  collision
);

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_SIZE-1:0]    ptr_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    idle;
    logic                    wr_go;
    logic                    rd_go;
    logic                    same_addr;
    logic [DATA_WIDTH-1:0]   merged_wr;

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NUM_BE-1:0]     lane_en
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int k = 0; k < NUM_BE; k++) begin
            if (lane_en[k]) begin
                res[k*BYTE_W +: BYTE_W] = new_word[k*BYTE_W +: BYTE_W];
            end
        end
        return res;
    endfunction

    // State register; ptr wraps to 0 on its own at the end of a sweep
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR) begin
                ptr_q <= ptr_q + 1'b1;
            end else if (init) begin
                ptr_q <= '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (init) state_d = CLEAR;
            CLEAR:   if (ptr_q == ADDR_SIZE'(DEPTH-1)) state_d = IDLE;
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        busy = (state_q == CLEAR);
    end

    assign idle      = (state_q == IDLE);
    assign wr_go     = idle & we;
    assign rd_go     = idle & re;
    assign same_addr = wr_go & rd_go & (wr_addr == rd_addr);
    assign merged_wr = merge_lanes(mem[wr_addr], data_in, be);

    // Storage: sweep has priority and user writes are blocked while it runs
    always_ff @(posedge clk) begin
        if (clr_n) begin
            if (state_q == CLEAR) begin
                mem[ptr_q] <= CLEAR_VAL;
            end else if (wr_go) begin
                mem[wr_addr] <= merged_wr;
            end
        end
    end

    // Read stage: merged_wr is the word memory will hold after this edge
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            data_out  <= '0;
            rd_valid  <= 1'b0;
            collision <= 1'b0;
        end else begin
            rd_valid  <= rd_go;
            collision <= same_addr;
            if (rd_go) begin
                data_out <= ((RDW_MODE != 0) && same_addr) ? merged_wr : mem[rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_ram_dualport_sync_param.sv
// Scoreboard bench: read-first and write-first instances driven in lockstep
// against an array-based reference model.
module tb_ram_dualport_sync_param;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          clr_n = 1'b0;
    logic          init = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [1:0]    be = '0;
    logic [DW-1:0] data_in = '0;
    logic          re = 1'b0;
    logic [AW-1:0] rd_addr = '0;

    logic          busy0, busy1, rv0, rv1, col0, col1;
    logic [DW-1:0] dout0, dout1;

    ram_dualport_sync_param #(.DATA_WIDTH(DW), .ADDR_SIZE(AW), .BYTE_W(8), .RDW_MODE(0)) dut0 (
        .clk(clk), .clr_n(clr_n), .init(init), .busy(busy0), .we(we), .wr_addr(wr_addr),
        .be(be), .data_in(data_in), .re(re), .rd_addr(rd_addr), .data_out(dout0),
        .rd_valid(rv0), .collision(col0));

    ram_dualport_sync_param #(.DATA_WIDTH(DW), .ADDR_SIZE(AW), .BYTE_W(8), .RDW_MODE(1)) dut1 (
        .clk(clk), .clr_n(clr_n), .init(init), .busy(busy1), .we(we), .wr_addr(wr_addr),
        .be(be), .data_in(data_in), .re(re), .rd_addr(rd_addr), .data_out(dout1),
        .rd_valid(rv1), .collision(col1));

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    bit            started = 0;

    logic [DW-1:0] mem_m [DEPTH];
    int            busy_left = DEPTH;
    logic          exp_busy, exp_rv, exp_col;
    logic [DW-1:0] exp_d0, exp_d1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [1:0] lanes);
        logic [DW-1:0] r;
        r[7:0]  = lanes[0] ? n[7:0]  : o[7:0];
        r[15:8] = lanes[1] ? n[15:8] : o[15:8];
        return r;
    endfunction

    // One clock of stimulus; the model predicts what the next posedge produces
    task automatic step(input bit rst_i, input bit init_i, input bit we_i, input int wa,
                        input logic [1:0] be_i, input logic [DW-1:0] din, input bit re_i,
                        input int ra);
        exp_t e;
        @(negedge clk);
        clr_n   = ~rst_i;
        init    = init_i;
        we      = we_i;
        wr_addr = AW'(wa);
        be      = be_i;
        data_in = din;
        re      = re_i;
        rd_addr = AW'(ra);
        if (rst_i) begin
            busy_left = DEPTH;
            exp_busy = 1'b1; exp_rv = 1'b0; exp_col = 1'b0;
            exp_d0 = '0; exp_d1 = '0;
            for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        end else if (busy_left > 0) begin
            busy_left--;
            exp_busy = (busy_left != 0);
            exp_rv = 1'b0; exp_col = 1'b0;
        end else begin
            exp_col = we_i && re_i && (wa == ra);
            exp_rv  = re_i;
            if (re_i) begin
                e.d0 = mem_m[ra];
                e.d1 = exp_col ? merge(mem_m[wa], din, be_i) : mem_m[ra];
                exp_q.push_back(e);
                exp_d0 = e.d0; exp_d1 = e.d1;
            end
            if (we_i) mem_m[wa] = merge(mem_m[wa], din, be_i);
            if (init_i) begin
                busy_left = DEPTH;
                for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
            end
            exp_busy = init_i;
        end
        started = 1'b1;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 2'b00, '0, 0, 0);
    endtask

    task automatic wr(input int a, input logic [1:0] b, input logic [DW-1:0] d);
        step(0, 0, 1, a, b, d, 0, 0);
    endtask

    task automatic rd(input int a);
        step(0, 0, 0, 0, 2'b00, '0, 1, a);
    endtask

    // Monitor: samples 1 time unit after each posedge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (started) begin
            chk("busy0", busy0, exp_busy);
            chk("busy1", busy1, exp_busy);
            chk("rd_valid0", rv0, exp_rv);
            chk("rd_valid1", rv1, exp_rv);
            chk("collision0", col0, exp_col);
            chk("collision1", col1, exp_col);
            if (rv0 === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_read", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("read_data_rf", dout0, e.d0);
                    chk("read_data_wf", dout1, e.d1);
                end
            end else begin
                chk("hold_data_rf", dout0, exp_d0);
                chk("hold_data_wf", dout1, exp_d1);
            end
        end
    end

    initial begin
        // Reset and initial sweep
        step(1, 0, 0, 0, 2'b00, '0, 0, 0);
        step(1, 0, 1, 3, 2'b11, 16'hFFFF, 1, 3);
        idle_n(8);
        for (int a = 0; a < DEPTH; a++) rd(a);
        idle_n(1);
        // Basic write/read and hold
        wr(5, 2'b11, 16'hA5C3);
        rd(5);
        idle_n(2);
        // Byte enables
        wr(5, 2'b01, 16'h1234);
        rd(5);
        wr(5, 2'b00, 16'hFFFF);
        rd(5);
        // Same-address collision
        wr(2, 2'b11, 16'h1111);
        step(0, 0, 1, 2, 2'b10, 16'h2222, 1, 2);
        rd(2);
        idle_n(1);
        // Init during operation with traffic and a second init mid-sweep
        for (int a = 0; a < DEPTH; a++) wr(a, 2'b11, 16'hBEEF);
        step(0, 1, 0, 0, 2'b00, '0, 0, 0);
        for (int i = 0; i < DEPTH; i++)
            step(0, (i == 3), 1, i, 2'b11, 16'h5555, 1, i);
        for (int a = 0; a < DEPTH; a++) rd(a);
        // Reset mid-sweep at ptr=4
        wr(1, 2'b11, 16'h7777);
        step(0, 1, 0, 0, 2'b00, '0, 0, 0);
        idle_n(4);
        step(1, 0, 0, 0, 2'b00, '0, 0, 0);
        idle_n(8);
        for (int a = 0; a < DEPTH; a++) rd(a);
        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            int wa, ra;
            wa = int'($urandom_range(0, 7));
            ra = ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, 7));
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) == 0),
                 $urandom_range(0, 1) == 1, wa, 2'($urandom_range(0, 3)), 16'($urandom),
                 $urandom_range(0, 1) == 1, ra);
        end
        idle_n(DEPTH + 2);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
